// File: rtl/axi_pkg.sv
// ============================================================================
// Module      : axi_pkg
// Description : Shared AXI constants and arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/axi_rr_pick2.sv
// ============================================================================
// Module      : axi_rr_pick2
// Description : Two-way round-robin picker; shared by the read and write arbiters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       pick,
  output logic       any
);

  assign any  = |req;
  // Contention favours whoever was not served last; a lone requester always wins.
  assign pick = (&req) ? ~last_grant : req[1];

endmodule

`default_nettype wire

// File: rtl/axi_read_arbiter.sv
// ============================================================================
// Module      : axi_read_arbiter
// Description : Round-robin arbiter sharing one AXI4 AR/R slave port between two masters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,

  input  logic [ADDRESS_WIDTH-1:0] s0_araddr,
  input  logic [7:0]               s0_arlen,
  input  logic [2:0]               s0_arsize,
  input  logic [1:0]               s0_arburst,
  input  logic                     s0_arvalid,
  output logic                     s0_arready,
  output logic [DATA_WIDTH-1:0]    s0_rdata,
  output logic [1:0]               s0_rresp,
  output logic                     s0_rlast,
  output logic                     s0_rvalid,
  input  logic                     s0_rready,

  input  logic [ADDRESS_WIDTH-1:0] s1_araddr,
  input  logic [7:0]               s1_arlen,
  input  logic [2:0]               s1_arsize,
  input  logic [1:0]               s1_arburst,
  input  logic                     s1_arvalid,
  output logic                     s1_arready,
  output logic [DATA_WIDTH-1:0]    s1_rdata,
  output logic [1:0]               s1_rresp,
  output logic                     s1_rlast,
  output logic                     s1_rvalid,
  input  logic                     s1_rready,

  output logic [ADDRESS_WIDTH-1:0] m_araddr,
  output logic [7:0]               m_arlen,
  output logic [2:0]               m_arsize,
  output logic [1:0]               m_arburst,
  output logic                     m_arvalid,
  input  logic                     m_arready,
  input  logic [DATA_WIDTH-1:0]    m_rdata,
  input  logic [1:0]               m_rresp,
  input  logic                     m_rlast,
  input  logic                     m_rvalid,
  output logic                     m_rready
);

  arb_state_e               r_state;
  logic                     r_grant;
  logic                     r_last_grant;
  logic [8:0]               r_beats_left;
  logic [ADDRESS_WIDTH-1:0] r_araddr;
  logic [7:0]               r_arlen;
  logic [2:0]               r_arsize;
  logic [1:0]               r_arburst;

  logic                     w_pick;
  logic                     w_any;
  logic [ADDRESS_WIDTH-1:0] w_sel_araddr;
  logic [7:0]               w_sel_arlen;
  logic [2:0]               w_sel_arsize;
  logic [1:0]               w_sel_arburst;
  logic                     w_sel_arvalid;
  logic                     w_sel_rready;
  logic                     w_ar_hs;
  logic                     w_r_hs;
  logic                     w_last_beat;
  logic                     w_unused;

  // Burst end comes from the internal beat counter, never from the slave.
  assign w_unused = m_rlast;

  axi_rr_pick2 u_pick (
    .req        ({s1_arvalid, s0_arvalid}),
    .last_grant (r_last_grant),
    .pick       (w_pick),
    .any        (w_any)
  );

  assign w_sel_araddr  = r_grant ? s1_araddr  : s0_araddr;
  assign w_sel_arlen   = r_grant ? s1_arlen   : s0_arlen;
  assign w_sel_arsize  = r_grant ? s1_arsize  : s0_arsize;
  assign w_sel_arburst = r_grant ? s1_arburst : s0_arburst;
  assign w_sel_arvalid = r_grant ? s1_arvalid : s0_arvalid;
  assign w_sel_rready  = r_grant ? s1_rready  : s0_rready;

  assign w_ar_hs     = (r_state == ARB_ADDR) && w_sel_arvalid && m_arready;
  assign w_r_hs      = (r_state == ARB_DATA) && m_rvalid && w_sel_rready;
  assign w_last_beat = (r_beats_left == 9'd1);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= ARB_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_beats_left <= 9'd0;
      r_araddr     <= '0;
      r_arlen      <= 8'd0;
      r_arsize     <= 3'd0;
      r_arburst    <= 2'd0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_state <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          // Shadow copy keeps m_ar* stable after the address phase ends.
          r_araddr  <= w_sel_araddr;
          r_arlen   <= w_sel_arlen;
          r_arsize  <= w_sel_arsize;
          r_arburst <= w_sel_arburst;
          if (w_ar_hs) begin
            r_beats_left <= {1'b0, w_sel_arlen} + 9'd1;
            r_state      <= ARB_DATA;
          end
        end
        ARB_DATA: begin
          if (w_r_hs) begin
            r_beats_left <= r_beats_left - 9'd1;
            if (w_last_beat) begin
              r_state      <= ARB_IDLE;
              r_last_grant <= r_grant;
            end
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    s0_arready = 1'b0;
    s0_rdata   = '0;
    s0_rresp   = RESP_OKAY;
    s0_rlast   = 1'b0;
    s0_rvalid  = 1'b0;
    s1_arready = 1'b0;
    s1_rdata   = '0;
    s1_rresp   = RESP_OKAY;
    s1_rlast   = 1'b0;
    s1_rvalid  = 1'b0;
    m_araddr   = r_araddr;
    m_arlen    = r_arlen;
    m_arsize   = r_arsize;
    m_arburst  = r_arburst;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    case (r_state)
      ARB_ADDR: begin
        m_araddr  = w_sel_araddr;
        m_arlen   = w_sel_arlen;
        m_arsize  = w_sel_arsize;
        m_arburst = w_sel_arburst;
        m_arvalid = w_sel_arvalid;
        if (r_grant) s1_arready = m_arready;
        else         s0_arready = m_arready;
      end
      ARB_DATA: begin
        m_rready = w_sel_rready;
        if (r_grant) begin
          s1_rdata  = m_rdata;
          s1_rresp  = m_rresp;
          s1_rvalid = m_rvalid;
          s1_rlast  = w_last_beat;
        end else begin
          s0_rdata  = m_rdata;
          s0_rresp  = m_rresp;
          s0_rvalid = m_rvalid;
          s0_rlast  = w_last_beat;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
// ============================================================================
// Module      : tb_axi_read_arbiter
// Description : Directed self-checking bench for axi_read_arbiter with a behavioural RAM slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_read_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;

  logic [7:0]  s_araddr  [2];
  logic [7:0]  s_arlen   [2];
  logic [2:0]  s_arsize  [2];
  logic [1:0]  s_arburst [2];
  logic        s_arvalid [2];
  logic        s_rready  [2];

  logic        s0_arready, s1_arready;
  logic [31:0] s0_rdata, s1_rdata;
  logic [1:0]  s0_rresp, s1_rresp;
  logic        s0_rlast, s1_rlast, s0_rvalid, s1_rvalid;

  logic [7:0]  m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;

  int checks = 0;
  int errors = 0;

  logic [31:0] q0_data[$];
  logic        q0_last[$];
  logic [31:0] q1_data[$];
  logic        q1_last[$];
  int          ar_log[$];
  int          s1_rv_cnt = 0;

  axi_read_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .s0_araddr  (s_araddr[0]),
    .s0_arlen   (s_arlen[0]),
    .s0_arsize  (s_arsize[0]),
    .s0_arburst (s_arburst[0]),
    .s0_arvalid (s_arvalid[0]),
    .s0_arready (s0_arready),
    .s0_rdata   (s0_rdata),
    .s0_rresp   (s0_rresp),
    .s0_rlast   (s0_rlast),
    .s0_rvalid  (s0_rvalid),
    .s0_rready  (s_rready[0]),
    .s1_araddr  (s_araddr[1]),
    .s1_arlen   (s_arlen[1]),
    .s1_arsize  (s_arsize[1]),
    .s1_arburst (s_arburst[1]),
    .s1_arvalid (s_arvalid[1]),
    .s1_arready (s1_arready),
    .s1_rdata   (s1_rdata),
    .s1_rresp   (s1_rresp),
    .s1_rlast   (s1_rlast),
    .s1_rvalid  (s1_rvalid),
    .s1_rready  (s_rready[1]),
    .m_araddr   (m_araddr),
    .m_arlen    (m_arlen),
    .m_arsize   (m_arsize),
    .m_arburst  (m_arburst),
    .m_arvalid  (m_arvalid),
    .m_arready  (m_arready),
    .m_rdata    (m_rdata),
    .m_rresp    (m_rresp),
    .m_rlast    (m_rlast),
    .m_rvalid   (m_rvalid),
    .m_rready   (m_rready)
  );

  always #5 aclk = ~aclk;

  // Byte-addressed RAM slave: byte n holds value n, 4-byte INCR beats, no rlast.
  logic       sl_busy;
  logic [7:0] sl_addr;
  logic [7:0] sl_cnt;

  assign m_arready = !sl_busy;
  assign m_rvalid  = sl_busy;
  assign m_rdata   = {sl_addr + 8'd3, sl_addr + 8'd2, sl_addr + 8'd1, sl_addr};
  assign m_rresp   = 2'b00;
  assign m_rlast   = 1'b0;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sl_busy <= 1'b0;
      sl_addr <= 8'd0;
      sl_cnt  <= 8'd0;
    end else if (!sl_busy && m_arvalid && m_arready) begin
      sl_busy <= 1'b1;
      sl_addr <= m_araddr;
      sl_cnt  <= m_arlen;
    end else if (sl_busy && m_rready) begin
      sl_addr <= sl_addr + 8'd4;
      if (sl_cnt == 8'd0) sl_busy <= 1'b0;
      else                sl_cnt  <= sl_cnt - 8'd1;
    end
  end

  always @(negedge aclk) begin
    if (s0_rvalid && s_rready[0]) begin
      q0_data.push_back(s0_rdata);
      q0_last.push_back(s0_rlast);
    end
    if (s1_rvalid && s_rready[1]) begin
      q1_data.push_back(s1_rdata);
      q1_last.push_back(s1_rlast);
    end
    if (s_arvalid[0] && s0_arready) ar_log.push_back(0);
    if (s_arvalid[1] && s1_arready) ar_log.push_back(1);
    if (s1_rvalid) s1_rv_cnt++;
  end

  function automatic logic [31:0] word(input logic [7:0] a);
    return {a + 8'd3, a + 8'd2, a + 8'd1, a};
  endfunction

  function automatic int qsize(input int who);
    return (who == 0) ? q0_data.size() : q1_data.size();
  endfunction

  function automatic logic arready_of(input int who);
    return (who == 0) ? s0_arready : s1_arready;
  endfunction

  task automatic wait_beats(input int who, input int target);
    for (int i = 0; i < 600 && qsize(who) < target; i++) begin
      @(negedge aclk); #1;
    end
    checks++;
    if (qsize(who) < target) begin
      errors++;
      $display("FAIL beat_timeout s%0d: got %0d beats, need %0d", who, qsize(who), target);
    end
  endtask

  task automatic request(input int who, input logic [7:0] addr, input logic [7:0] len);
    int  start;
    bit  done;
    start = qsize(who);
    @(posedge aclk); #1;
    s_araddr[who]  = addr;
    s_arlen[who]   = len;
    s_arsize[who]  = 3'd2;
    s_arburst[who] = 2'd1;
    s_arvalid[who] = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge aclk);
      if (arready_of(who)) done = 1'b1;
    end
    @(posedge aclk); #1;
    s_arvalid[who] = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL ar_timeout s%0d: arready never seen, need 1", who);
    end
    wait_beats(who, start + int'(len) + 1);
  endtask

  task automatic clear_logs();
    q0_data.delete(); q0_last.delete();
    q1_data.delete(); q1_last.delete();
    ar_log.delete();
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({m_arvalid, m_rready, s0_arready, s1_arready, s0_rvalid, s1_rvalid, s0_rlast, s1_rlast} !== 8'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, need 00000000",
               {m_arvalid, m_rready, s0_arready, s1_arready, s0_rvalid, s1_rvalid, s0_rlast, s1_rlast});
    end
    checks++;
    if ({m_araddr, s0_rdata, s1_rdata} !== 72'd0) begin
      errors++;
      $display("FAIL reset_data: got %h, need 0", {m_araddr, s0_rdata, s1_rdata});
    end
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic test_simultaneous();
    clear_logs();
    fork
      request(0, 8'h00, 8'd0);
      request(1, 8'h40, 8'd0);
    join
    checks++;
    if (ar_log.size() != 2 || ar_log[0] != 0 || ar_log[1] != 1) begin
      errors++;
      $display("FAIL simul_order: got size %0d first %0d, need size 2 order s0,s1",
               ar_log.size(), (ar_log.size() > 0) ? ar_log[0] : -1);
    end
    checks++;
    if (q1_data.size() != 1 || q1_data[0] !== 32'h43424140 || q1_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL simul_s1_data: got %h last %b, need 43424140 last 1",
               (q1_data.size() > 0) ? q1_data[0] : 32'hx, (q1_last.size() > 0) ? q1_last[0] : 1'bx);
    end
  endtask

  task automatic test_fairness();
    int n0;
    int bad;
    clear_logs();
    fork
      begin for (int k = 0; k < 4; k++) request(0, 8'h80, 8'd1); end
      begin for (int k = 0; k < 4; k++) request(1, 8'hA0, 8'd1); end
    join
    bad = 0;
    n0 = 0;
    foreach (ar_log[i]) begin
      if (ar_log[i] != (i % 2)) bad++;
      if (ar_log[i] == 0) n0++;
    end
    checks++;
    if (ar_log.size() != 8 || bad != 0) begin
      errors++;
      $display("FAIL rr_alternate: got %0d grants, %0d out of order, need 8 alternating from s0", ar_log.size(), bad);
    end
    checks++;
    if (n0 != 4) begin
      errors++;
      $display("FAIL rr_share: got s0 grants %0d, need 4", n0);
    end
  endtask

  task automatic test_single();
    int rv_before;
    clear_logs();
    rv_before = s1_rv_cnt;
    @(posedge aclk); #1;
    s_araddr[0] = 8'h10; s_arlen[0] = 8'd3; s_arsize[0] = 3'd2; s_arburst[0] = 2'd1;
    s_arvalid[0] = 1'b1;
    checks++;
    if (m_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_lat0: m_arvalid got %b, need 0", m_arvalid);
    end
    @(posedge aclk); #1;
    checks++;
    if ({m_arvalid, s0_arready, s1_arready} !== 3'b110 || m_araddr !== 8'h10 || m_arlen !== 8'd3
        || m_arsize !== 3'd2 || m_arburst !== 2'd1) begin
      errors++;
      $display("FAIL single_ar: got v/r0/r1 %b addr %h len %0d size %0d burst %0d, need 110 10 3 2 1",
               {m_arvalid, s0_arready, s1_arready}, m_araddr, m_arlen, m_arsize, m_arburst);
    end
    @(posedge aclk); #1;
    s_arvalid[0] = 1'b0;
    checks++;
    if (s0_rvalid !== 1'b1 || s0_rresp !== 2'b00 || s0_rlast !== 1'b0) begin
      errors++;
      $display("FAIL single_beat1: got rvalid %b rresp %0d rlast %b, need 1 0 0", s0_rvalid, s0_rresp, s0_rlast);
    end
    wait_beats(0, 4);
    checks++;
    if (q0_data.size() != 4 || q0_data[0] !== 32'h13121110 || q0_data[1] !== 32'h17161514
        || q0_data[2] !== 32'h1B1A1918 || q0_data[3] !== 32'h1F1E1D1C) begin
      errors++;
      $display("FAIL single_data: got %0d beats first %h, need 4 beats 13121110..1f1e1d1c",
               q0_data.size(), (q0_data.size() > 0) ? q0_data[0] : 32'hx);
    end
    checks++;
    if (q0_last.size() != 4 || {q0_last[0], q0_last[1], q0_last[2], q0_last[3]} !== 4'b0001) begin
      errors++;
      $display("FAIL single_rlast: got %0d flags, need 0001", q0_last.size());
    end
    @(posedge aclk); #1;
    checks++;
    if (s1_rv_cnt != rv_before || m_arvalid !== 1'b0 || m_araddr !== 8'h10) begin
      errors++;
      $display("FAIL single_after: s1 rvalid cycles %0d arvalid %b araddr %h, need 0 0 10",
               s1_rv_cnt - rv_before, m_arvalid, m_araddr);
    end
  endtask

  task automatic test_backpressure();
    bit done;
    int bad_mirror;
    int bad_data;
    clear_logs();
    done = 1'b0;
    bad_mirror = 0;
    fork
      begin request(1, 8'h60, 8'd7); done = 1'b1; end
      begin
        for (int i = 0; i < 200 && !done; i++) begin
          @(posedge aclk); #1;
          s_rready[1] = ~s_rready[1];
          #1;
          if (s1_rvalid && (m_rready !== s_rready[1])) bad_mirror++;
        end
      end
    join
    s_rready[1] = 1'b1;
    checks++;
    if (bad_mirror != 0) begin
      errors++;
      $display("FAIL bp_mirror: got %0d mismatched cycles, need 0", bad_mirror);
    end
    bad_data = 0;
    foreach (q1_data[i]) begin
      if (q1_data[i] !== word(8'h60 + 8'(4 * i))) bad_data++;
      if (q1_last[i] !== (i == 7)) bad_data++;
    end
    checks++;
    if (q1_data.size() != 8 || bad_data != 0) begin
      errors++;
      $display("FAIL bp_beats: got %0d beats with %0d bad, need 8 in order", q1_data.size(), bad_data);
    end
  endtask

  task automatic test_max_len();
    int bad_data;
    int n_last;
    clear_logs();
    request(0, 8'h00, 8'd255);
    bad_data = 0;
    n_last = 0;
    foreach (q0_data[i]) begin
      if (q0_data[i] !== word(8'(4 * i))) bad_data++;
      if (q0_last[i] === 1'b1) n_last++;
    end
    checks++;
    if (q0_data.size() != 256 || bad_data != 0) begin
      errors++;
      $display("FAIL max_beats: got %0d beats with %0d bad, need 256 in order", q0_data.size(), bad_data);
    end
    checks++;
    if (n_last != 1 || q0_last.size() != 256 || q0_last[255] !== 1'b1) begin
      errors++;
      $display("FAIL max_rlast: got %0d rlast beats, need exactly 1 on beat 256", n_last);
    end
    @(posedge aclk); #1;
    checks++;
    if ({s0_rvalid, s0_rlast, m_rready, m_arvalid} !== 4'b0000) begin
      errors++;
      $display("FAIL max_idle: got %b, need 0000", {s0_rvalid, s0_rlast, m_rready, m_arvalid});
    end
  endtask

  task automatic test_reset_mid_burst();
    bit done;
    clear_logs();
    @(posedge aclk); #1;
    s_araddr[0] = 8'h20; s_arlen[0] = 8'd5; s_arsize[0] = 3'd2; s_arburst[0] = 2'd1;
    s_arvalid[0] = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge aclk);
      if (s0_arready) done = 1'b1;
    end
    @(posedge aclk); #1;
    s_arvalid[0] = 1'b0;
    wait_beats(0, 2);
    #2;
    aresetn = 1'b0;
    #1;
    checks++;
    if ({s0_rvalid, s0_rlast, s0_arready, s1_arready, m_arvalid, m_rready, s1_rvalid} !== 7'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %b, need 0000000",
               {s0_rvalid, s0_rlast, s0_arready, s1_arready, m_arvalid, m_rready, s1_rvalid});
    end
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    clear_logs();
    request(1, 8'h40, 8'd0);
    checks++;
    if (q1_data.size() != 1 || q1_data[0] !== 32'h43424140 || q1_last[0] !== 1'b1 || q0_data.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_regrant: got s1 beats %0d s0 beats %0d, need 1 beat 43424140 last 1 and 0",
               q1_data.size(), q0_data.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      s_araddr[i]  = 8'd0;
      s_arlen[i]   = 8'd0;
      s_arsize[i]  = 3'd0;
      s_arburst[i] = 2'd0;
      s_arvalid[i] = 1'b0;
      s_rready[i]  = 1'b1;
    end
    test_reset();
    test_simultaneous();
    test_fairness();
    test_single();
    test_backpressure();
    test_max_len();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
